// File: rtl/ni_fifo_pkg.sv
// Shared types, defaults and width helper for the network-interface flit FIFO.
package ni_fifo_pkg;

  localparam int NI_FIFO_DW_DEF    = 64;
  localparam int NI_FIFO_DEPTH_DEF = 32;
  localparam int NI_FIFO_AF_DEF    = 28;

  typedef logic [NI_FIFO_DW_DEF-1:0] flit_t;

  // Address width for a storage array of 'depth' entries (at least one bit).
  function automatic int ni_fifo_clog2(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/ni_fifo_ptr.sv
// Wrap-bit FIFO pointer: CW bits, the MSB toggles each time the address wraps.
// 'load' (used for flush) has priority over 'inc'.
module ni_fifo_ptr #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] ptr
);

  logic [CW-1:0] ptr_q;
  logic [CW-1:0] ptr_d;

  // Next pointer: load wins, otherwise advance by one (natural modulo 2^CW wrap).
  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = load_val;
    end else if (inc) begin
      ptr_d = ptr_q + CW'(1);
    end
  end

  // Pointer register, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/ni_flit_fifo.sv
// First-word-fall-through flit FIFO with occupancy count, almost-full flag,
// synchronous flush and a high-watermark register.
// Optional macro NI_FIFO_BYPASS_EN: zero-latency pass-through when empty.
module ni_flit_fifo
  import ni_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = NI_FIFO_DW_DEF,
  parameter  int DEPTH      = NI_FIFO_DEPTH_DEF,
  parameter  int AF_THRESH  = NI_FIFO_AF_DEF,
  localparam int AW         = ni_fifo_clog2(DEPTH),
  localparam int CW         = AW + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CW-1:0]         count,
  output logic                  almost_full,
  output logic [CW-1:0]         max_level
);

  localparam logic [CW-1:0] AF_C = CW'(AF_THRESH);

  logic [DATA_WIDTH-1:0] storage_q [DEPTH];

  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          empty;
  logic          full;
  logic          pass_through;
  logic          wr_fire;
  logic          rd_fire;
  logic [CW-1:0] count_next;
  logic [CW-1:0] max_level_q;
  logic [CW-1:0] max_level_d;

  assign wr_addr = wr_ptr[AW-1:0];
  assign rd_addr = rd_ptr[AW-1:0];

  // Wrap-bit comparison lets all DEPTH entries be used.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_addr == rd_addr) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count = wr_ptr - rd_ptr;

  // in_ready and almost_full depend on state only, so a read never opens a same-cycle write slot.
  assign in_ready    = !full;
  assign almost_full = (count >= AF_C);

`ifdef NI_FIFO_BYPASS_EN
  // An empty FIFO presents the incoming flit directly; it is consumed without touching storage.
  assign pass_through = empty && in_valid && out_ready && !flush;
  assign out_valid    = !empty || in_valid;
  assign out_data     = empty ? in_data : storage_q[rd_addr];
`else
  assign pass_through = 1'b0;
  assign out_valid    = !empty;
  assign out_data     = storage_q[rd_addr];
`endif

  // Flush discards any transfer attempted in the same cycle.
  assign wr_fire = in_valid && in_ready && !flush && !pass_through;
  assign rd_fire = !empty && out_ready && !flush;

  ni_fifo_ptr #(.CW(CW)) u_wr_ptr (
    .clk      (clk),
    .reset    (reset),
    .inc      (wr_fire),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (wr_ptr)
  );

  // Flush empties the FIFO by snapping the read pointer onto the write pointer.
  ni_fifo_ptr #(.CW(CW)) u_rd_ptr (
    .clk      (clk),
    .reset    (reset),
    .inc      (rd_fire),
    .load     (flush),
    .load_val (wr_ptr),
    .ptr      (rd_ptr)
  );

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      storage_q[wr_addr] <= in_data;
    end
  end

  // Occupancy after this edge and the resulting watermark.
  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      count_next = count + CW'(wr_fire) - CW'(rd_fire);
    end
    max_level_d = (count_next > max_level_q) ? count_next : max_level_q;
  end

  // Watermark register: only reset clears it, flush does not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_level_q <= '0;
    end else begin
      max_level_q <= max_level_d;
    end
  end

  assign max_level = max_level_q;

endmodule
